// File: rtl/fp_align_stage.sv
// fp_align_stage: operand-alignment stage of the floating-point adder.
// Stage 1 unpacks both operands, orders them by magnitude and registers the
// exponent difference. Stage 2 right-shifts the smaller significand with
// guard/round/sticky retention. Both stages use valid/ready flow control.
// Optional build macro FP_ALIGN_FTZ_EN: flush subnormal inputs to signed zero.
module fp_align_stage #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [EXP_W+MAN_W:0]   a,
    input  logic [EXP_W+MAN_W:0]   b,
    input  logic                   op_sub,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W-1:0]       out_exp,
    output logic [MAN_W+3:0]       out_man_l,
    output logic [MAN_W+3:0]       out_man_s,
    output logic                   out_sign_l,
    output logic                   out_sign_s,
    output logic                   out_eff_sub,
    output logic                   out_swapped,
    output logic                   out_nan,
    output logic                   out_inf
);
    localparam int SIG_W = MAN_W + 4;
    localparam int W     = EXP_W + MAN_W + 1;

    // Flow control
    logic s2_adv_s;

    // Stage 1 unpacked fields
    logic [EXP_W-1:0] exp_a_s, exp_b_s, eexp_a_s, eexp_b_s;
    logic [MAN_W-1:0] frac_a_s, frac_b_s;
    logic             sign_a_s, sign_b_s, swap_s;
    logic             nan_a_s, nan_b_s, inf_a_s, inf_b_s, nan_s;
    logic [SIG_W-1:0] sig_a_s, sig_b_s;

    // Stage 1 registers
    logic             s1_valid_d, s1_valid_q;
    logic [EXP_W-1:0] s1_diff_d, s1_diff_q, s1_exp_d, s1_exp_q;
    logic [SIG_W-1:0] s1_sig_l_d, s1_sig_l_q, s1_sig_s_d, s1_sig_s_q;
    logic             s1_sign_l_d, s1_sign_l_q, s1_sign_s_d, s1_sign_s_q;
    logic             s1_swap_d, s1_swap_q, s1_nan_d, s1_nan_q, s1_inf_d, s1_inf_q;

    // Stage 2 alignment and registers
    logic [SIG_W-1:0] lost_s, man_s_s;
    logic             s2_valid_d, s2_valid_q;
    logic [EXP_W-1:0] s2_exp_d, s2_exp_q;
    logic [SIG_W-1:0] s2_man_l_d, s2_man_l_q, s2_man_s_d, s2_man_s_q;
    logic             s2_sign_l_d, s2_sign_l_q, s2_sign_s_d, s2_sign_s_q;
    logic             s2_swap_d, s2_swap_q, s2_nan_d, s2_nan_q, s2_inf_d, s2_inf_q;

    // A full output stage frees up when downstream takes it; stage 1 follows
    assign s2_adv_s = !s2_valid_q || out_ready;
    assign in_ready = !s1_valid_q || s2_adv_s;

    // Field extraction, with optional flush of subnormals to signed zero
    always_comb begin
        sign_a_s = a[W-1];
        sign_b_s = b[W-1] ^ op_sub;
        exp_a_s  = a[W-2 -: EXP_W];
        exp_b_s  = b[W-2 -: EXP_W];
        frac_a_s = a[MAN_W-1:0];
        frac_b_s = b[MAN_W-1:0];
`ifdef FP_ALIGN_FTZ_EN
        if (exp_a_s == {EXP_W{1'b0}}) frac_a_s = {MAN_W{1'b0}};
        else                          frac_a_s = a[MAN_W-1:0];
        if (exp_b_s == {EXP_W{1'b0}}) frac_b_s = {MAN_W{1'b0}};
        else                          frac_b_s = b[MAN_W-1:0];
`endif
    end

    // Unpack significands, classify specials and order operands by magnitude
    always_comb begin
        eexp_a_s = (exp_a_s == {EXP_W{1'b0}}) ? {{(EXP_W-1){1'b0}}, 1'b1} : exp_a_s;
        eexp_b_s = (exp_b_s == {EXP_W{1'b0}}) ? {{(EXP_W-1){1'b0}}, 1'b1} : exp_b_s;
        sig_a_s  = {(exp_a_s != {EXP_W{1'b0}}), frac_a_s, 3'b000};
        sig_b_s  = {(exp_b_s != {EXP_W{1'b0}}), frac_b_s, 3'b000};
        nan_a_s  = (exp_a_s == {EXP_W{1'b1}}) && (frac_a_s != {MAN_W{1'b0}});
        nan_b_s  = (exp_b_s == {EXP_W{1'b1}}) && (frac_b_s != {MAN_W{1'b0}});
        inf_a_s  = (exp_a_s == {EXP_W{1'b1}}) && (frac_a_s == {MAN_W{1'b0}});
        inf_b_s  = (exp_b_s == {EXP_W{1'b1}}) && (frac_b_s == {MAN_W{1'b0}});
        // Inf - Inf (after sign adjustment) has no meaningful result
        nan_s    = nan_a_s || nan_b_s || (inf_a_s && inf_b_s && (sign_a_s ^ sign_b_s));
        // Equal magnitudes keep A as the larger operand
        swap_s   = {exp_b_s, frac_b_s} > {exp_a_s, frac_a_s};
    end

    // Stage 1 next state: load on accepted input, otherwise hold
    always_comb begin
        s1_valid_d  = in_ready ? in_valid : s1_valid_q;
        s1_diff_d   = s1_diff_q;
        s1_exp_d    = s1_exp_q;
        s1_sig_l_d  = s1_sig_l_q;
        s1_sig_s_d  = s1_sig_s_q;
        s1_sign_l_d = s1_sign_l_q;
        s1_sign_s_d = s1_sign_s_q;
        s1_swap_d   = s1_swap_q;
        s1_nan_d    = s1_nan_q;
        s1_inf_d    = s1_inf_q;
        if (in_valid && in_ready) begin
            s1_swap_d   = swap_s;
            s1_nan_d    = nan_s;
            s1_inf_d    = (inf_a_s || inf_b_s) && !nan_s;
            if (swap_s) begin
                s1_exp_d    = eexp_b_s;
                s1_diff_d   = eexp_b_s - eexp_a_s;
                s1_sig_l_d  = sig_b_s;
                s1_sig_s_d  = sig_a_s;
                s1_sign_l_d = sign_b_s;
                s1_sign_s_d = sign_a_s;
            end else begin
                s1_exp_d    = eexp_a_s;
                s1_diff_d   = eexp_a_s - eexp_b_s;
                s1_sig_l_d  = sig_a_s;
                s1_sig_s_d  = sig_b_s;
                s1_sign_l_d = sign_a_s;
                s1_sign_s_d = sign_b_s;
            end
        end else begin
            s1_swap_d = s1_swap_q;
        end
    end

    // Right-shift the smaller significand, folding lost bits into the sticky bit
    always_comb begin
        lost_s  = {SIG_W{1'b0}};
        man_s_s = s1_sig_s_q;
        if (int'(s1_diff_q) >= SIG_W) begin
            man_s_s = {{(SIG_W-1){1'b0}}, |s1_sig_s_q};
        end else begin
            lost_s     = s1_sig_s_q & ~({SIG_W{1'b1}} << s1_diff_q);
            man_s_s    = s1_sig_s_q >> s1_diff_q;
            man_s_s[0] = man_s_s[0] | (|lost_s);
        end
    end

    // Stage 2 next state: advance stage 1 content when the output slot frees
    always_comb begin
        s2_valid_d  = s2_adv_s ? s1_valid_q : s2_valid_q;
        s2_exp_d    = s2_exp_q;
        s2_man_l_d  = s2_man_l_q;
        s2_man_s_d  = s2_man_s_q;
        s2_sign_l_d = s2_sign_l_q;
        s2_sign_s_d = s2_sign_s_q;
        s2_swap_d   = s2_swap_q;
        s2_nan_d    = s2_nan_q;
        s2_inf_d    = s2_inf_q;
        if (s2_adv_s && s1_valid_q) begin
            s2_exp_d    = s1_exp_q;
            s2_man_l_d  = s1_sig_l_q;
            s2_man_s_d  = man_s_s;
            s2_sign_l_d = s1_sign_l_q;
            s2_sign_s_d = s1_sign_s_q;
            s2_swap_d   = s1_swap_q;
            s2_nan_d    = s1_nan_q;
            s2_inf_d    = s1_inf_q;
        end else begin
            s2_swap_d = s2_swap_q;
        end
    end

    // Pipeline registers; reset discards any in-flight data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_diff_q   <= {EXP_W{1'b0}};
            s1_exp_q    <= {EXP_W{1'b0}};
            s1_sig_l_q  <= {SIG_W{1'b0}};
            s1_sig_s_q  <= {SIG_W{1'b0}};
            s1_sign_l_q <= 1'b0;
            s1_sign_s_q <= 1'b0;
            s1_swap_q   <= 1'b0;
            s1_nan_q    <= 1'b0;
            s1_inf_q    <= 1'b0;
            s2_valid_q  <= 1'b0;
            s2_exp_q    <= {EXP_W{1'b0}};
            s2_man_l_q  <= {SIG_W{1'b0}};
            s2_man_s_q  <= {SIG_W{1'b0}};
            s2_sign_l_q <= 1'b0;
            s2_sign_s_q <= 1'b0;
            s2_swap_q   <= 1'b0;
            s2_nan_q    <= 1'b0;
            s2_inf_q    <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_diff_q   <= s1_diff_d;
            s1_exp_q    <= s1_exp_d;
            s1_sig_l_q  <= s1_sig_l_d;
            s1_sig_s_q  <= s1_sig_s_d;
            s1_sign_l_q <= s1_sign_l_d;
            s1_sign_s_q <= s1_sign_s_d;
            s1_swap_q   <= s1_swap_d;
            s1_nan_q    <= s1_nan_d;
            s1_inf_q    <= s1_inf_d;
            s2_valid_q  <= s2_valid_d;
            s2_exp_q    <= s2_exp_d;
            s2_man_l_q  <= s2_man_l_d;
            s2_man_s_q  <= s2_man_s_d;
            s2_sign_l_q <= s2_sign_l_d;
            s2_sign_s_q <= s2_sign_s_d;
            s2_swap_q   <= s2_swap_d;
            s2_nan_q    <= s2_nan_d;
            s2_inf_q    <= s2_inf_d;
        end
    end

    assign out_valid   = s2_valid_q;
    assign out_exp     = s2_exp_q;
    assign out_man_l   = s2_man_l_q;
    assign out_man_s   = s2_man_s_q;
    assign out_sign_l  = s2_sign_l_q;
    assign out_sign_s  = s2_sign_s_q;
    assign out_eff_sub = s2_sign_l_q ^ s2_sign_s_q;
    assign out_swapped = s2_swap_q;
    assign out_nan     = s2_nan_q;
    assign out_inf     = s2_inf_q;

endmodule

// File: tb/tb_fp_align_stage.sv
// Self-checking bench for fp_align_stage: directed cases, backpressure,
// asynchronous reset and randomized traffic against a behavioural model.
module tb_fp_align_stage;
    localparam int R_W = 68;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic        op_sub = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [7:0]  out_exp;
    logic [26:0] out_man_l, out_man_s;
    logic        out_sign_l, out_sign_s, out_eff_sub, out_swapped, out_nan, out_inf;
    logic [R_W-1:0] obs;

    int n_checks = 0;
    int n_pass   = 0;
    int n_out    = 0;
    logic [R_W-1:0] exp_q[$];
    logic [R_W-1:0] held;
    logic           held_v = 1'b0;

    fp_align_stage dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .op_sub(op_sub), .out_valid(out_valid), .out_ready(out_ready),
        .out_exp(out_exp), .out_man_l(out_man_l), .out_man_s(out_man_s),
        .out_sign_l(out_sign_l), .out_sign_s(out_sign_s), .out_eff_sub(out_eff_sub),
        .out_swapped(out_swapped), .out_nan(out_nan), .out_inf(out_inf)
    );

    always #5 clk = ~clk;

    assign obs = {out_exp, out_man_l, out_man_s, out_sign_l, out_sign_s,
                  out_eff_sub, out_swapped, out_nan, out_inf};

    task automatic check_eq(input string tag, input logic [R_W-1:0] got, input logic [R_W-1:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, want);
    endtask

    // Behavioural reference: value-level arithmetic on the IEEE fields
    function automatic logic [R_W-1:0] ref_model(input logic [31:0] x, input logic [31:0] y, input logic sub);
        longint ea, eb, fa, fb, siga, sigb, el, es, sigl, sigs, d, pw, ms;
        logic sa, sb, sl, ss, swap, na, nb, ia, ib, nan, inf;
        ea = longint'(x[30:23]); fa = longint'(x[22:0]);
        eb = longint'(y[30:23]); fb = longint'(y[22:0]);
        sa = x[31]; sb = y[31] ^ sub;
`ifdef FP_ALIGN_FTZ_EN
        if (ea == 0) fa = 0;
        if (eb == 0) fb = 0;
`endif
        na = (ea == 255) && (fa != 0);
        nb = (eb == 255) && (fb != 0);
        ia = (ea == 255) && (fa == 0);
        ib = (eb == 255) && (fb == 0);
        swap = (eb * 8388608 + fb) > (ea * 8388608 + fa);
        siga = (((ea == 0) ? 0 : 8388608) + fa) * 8;
        sigb = (((eb == 0) ? 0 : 8388608) + fb) * 8;
        if (ea == 0) ea = 1;
        if (eb == 0) eb = 1;
        if (swap) begin
            el = eb; es = ea; sigl = sigb; sigs = siga; sl = sb; ss = sa;
        end else begin
            el = ea; es = eb; sigl = siga; sigs = sigb; sl = sa; ss = sb;
        end
        d = el - es;
        if (d >= 27) begin
            ms = (sigs != 0) ? 1 : 0;
        end else begin
            pw = longint'(1) << d;
            ms = sigs / pw;
            if ((sigs % pw) != 0) ms = ms | 1;
        end
        nan = na || nb || (ia && ib && (sa != sb));
        inf = (ia || ib) && !nan;
        return {el[7:0], sigl[26:0], ms[26:0], sl, ss, sl ^ ss, swap, nan, inf};
    endfunction

    function automatic logic [31:0] rand_op();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 7))
            0: r[30:23] = 8'h00;
            1: r[30:0]  = 31'd0;
            2: begin r[30:23] = 8'hFF; r[22:0] = 23'd0; end
            3: r[30:23] = 8'hFF;
            4, 5: r[30:23] = 8'd118 + 8'($urandom_range(0, 20));
            default: r = r;
        endcase
        return r;
    endfunction

    // Scoreboard: record accepted inputs, compare outputs in order, check stall stability
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            held_v <= 1'b0;
        end else begin
            if (held_v && out_valid) check_eq("stall_stable", obs, held);
            if (out_valid && out_ready) begin
                n_out++;
                if (exp_q.size() == 0) check_eq("unexpected_out", R_W'(exp_q.size()), R_W'(1));
                else check_eq("result", obs, exp_q.pop_front());
            end
            if (in_valid && in_ready) exp_q.push_back(ref_model(a, b, op_sub));
            held_v <= out_valid && !out_ready;
            held   <= obs;
        end
    end

    // Offer one operand pair with out_ready=1; returns with its result on the outputs
    task automatic run_one(input logic [31:0] x, input logic [31:0] y, input logic sub);
        int t1;
        int t2;
        out_ready = 1'b1; in_valid = 1'b1; a = x; b = y; op_sub = sub;
        t1 = 0;
        while (!in_ready && t1 < 20) begin @(posedge clk); #1; t1++; end
        @(posedge clk); #1; in_valid = 1'b0;
        t2 = 0;
        while (!out_valid && t2 < 20) begin @(posedge clk); #1; t2++; end
        check_eq("handshake_bound", R_W'((t1 < 20) && (t2 < 20)), R_W'(1));
    endtask

    task automatic drain();
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (4) begin @(posedge clk); #1; end
    endtask

    initial begin
        int acc;
        int n0;
        #1 rst_n = 1'b0;
        #15;
        check_eq("rst_out_valid", R_W'(out_valid), R_W'(0));
        check_eq("rst_data", obs, R_W'(0));
        @(posedge clk); #1 rst_n = 1'b1;
        check_eq("rst_in_ready", R_W'(in_ready), R_W'(1));

        run_one(32'h3F800000, 32'h3F800000, 1'b0);
        check_eq("t1_exp", R_W'(out_exp), R_W'(8'h7F));
        check_eq("t1_man_l", R_W'(out_man_l), R_W'(27'h4000000));
        check_eq("t1_man_s", R_W'(out_man_s), R_W'(27'h4000000));
        check_eq("t1_eff_swp", R_W'({out_eff_sub, out_swapped}), R_W'(2'b00));

        run_one(32'h40400000, 32'h3FC00000, 1'b1);
        check_eq("t2_exp", R_W'(out_exp), R_W'(8'h80));
        check_eq("t2_man_l", R_W'(out_man_l), R_W'(27'h6000000));
        check_eq("t2_man_s", R_W'(out_man_s), R_W'(27'h3000000));
        check_eq("t2_sgn_eff", R_W'({out_sign_s, out_eff_sub}), R_W'(2'b11));

        run_one(32'h3F800000, 32'h40000000, 1'b0);
        check_eq("t3_swapped", R_W'(out_swapped), R_W'(1));
        check_eq("t3_exp", R_W'(out_exp), R_W'(8'h80));
        check_eq("t3_man_l", R_W'(out_man_l), R_W'(27'h4000000));
        check_eq("t3_man_s", R_W'(out_man_s), R_W'(27'h2000000));

        run_one(32'h3F800000, 32'h30800000, 1'b0);
        check_eq("t4_sticky", R_W'(out_man_s), R_W'(27'h0000001));

        run_one(32'h7F800000, 32'h7F800000, 1'b1);
        check_eq("t5_nan_inf", R_W'({out_nan, out_inf}), R_W'(2'b10));

        // Backpressure: only two slots exist while the output is blocked
        drain();
        n0 = n_out;
        out_ready = 1'b0; acc = 0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; a = rand_op(); b = rand_op(); op_sub = 1'($urandom);
            acc += int'(in_ready);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        check_eq("bp_accepted", R_W'(acc), R_W'(2));
        check_eq("bp_in_ready", R_W'(in_ready), R_W'(0));
        repeat (3) begin @(posedge clk); #1; end
        drain();
        check_eq("bp_emerged", R_W'(n_out - n0), R_W'(2));
        check_eq("bp_queue_empty", R_W'(exp_q.size()), R_W'(0));

        // Asynchronous reset while a result is waiting
        out_ready = 1'b0;
        in_valid = 1'b1; a = 32'h40400000; b = 32'h3F800000; op_sub = 1'b0;
        @(posedge clk); #1;
        a = 32'h41000000;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check_eq("pre_rst_valid", R_W'(out_valid), R_W'(1));
        #2 rst_n = 1'b0;
        #1;
        check_eq("async_rst_valid", R_W'(out_valid), R_W'(0));
        check_eq("async_rst_data", obs, R_W'(0));
        @(posedge clk); #1 rst_n = 1'b1;
        check_eq("post_rst_in_ready", R_W'(in_ready), R_W'(1));
        out_ready = 1'b1; in_valid = 1'b1; a = 32'hC0A00000; b = 32'h3E000000; op_sub = 1'b1;
        @(posedge clk); #1 in_valid = 1'b0;
        check_eq("lat_1cyc", R_W'(out_valid), R_W'(0));
        @(posedge clk); #1;
        check_eq("lat_2cyc", R_W'(out_valid), R_W'(1));
        drain();

        // Randomized traffic with random backpressure
        for (int i = 0; i < 3000; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            a         = rand_op();
            b         = rand_op();
            op_sub    = 1'($urandom);
            out_ready = ($urandom_range(0, 2) != 0);
            @(posedge clk); #1;
        end
        drain();
        check_eq("final_queue_empty", R_W'(exp_q.size()), R_W'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/fp_align_stage.md
Name: fp_align_stage

Overview:
- Pipelined operand-alignment stage of the floating-point adder.
- Unpacks two IEEE-754 operands and orders them by magnitude. Right-shifts the smaller significand by the exponent difference, keeping guard/round/sticky bits.
- Hands the aligned significand pair to the mantissa adder stage, which is built from 4-bit carry-lookahead slices.
- Two register stages with valid/ready flow control.

Parameters:
- EXP_W, 8, exponent field width.
- MAN_W, 23, stored fraction width. Aligned significand width is SIG_W = MAN_W+4: hidden bit, fraction, G, R, S.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand pair present.
- in_ready  output  1  stage can accept operands this cycle.
- a  input  EXP_W+MAN_W+1  operand A, IEEE format.
- b  input  EXP_W+MAN_W+1  operand B, IEEE format.
- op_sub  input  1  1 = compute A-B (B sign inverted).
- out_valid  output  1  aligned result present.
- out_ready  input  1  downstream accepts.
- out_exp  output  EXP_W  common (larger) exponent; subnormals reported as 1.
- out_man_l  output  SIG_W  larger significand, left-justified with GRS = 000.
- out_man_s  output  SIG_W  smaller significand after shift, with GRS.
- out_sign_l  output  1  sign of larger operand.
- out_sign_s  output  1  effective sign of smaller operand.
- out_eff_sub  output  1  out_sign_l XOR out_sign_s.
- out_swapped  output  1  B was larger than A.
- out_nan  output  1  result must be quiet NaN.
- out_inf  output  1  result must be infinity with sign out_sign_l.

Behaviour:
- Reset, asynchronous while rst_n=0: both stage valids cleared; out_valid=0; all data outputs 0; in_ready=1 after release. Reset mid-transfer discards in-flight data.
- Transfer rules: input accepted on in_valid&in_ready; output consumed on out_valid&out_ready.
- Pipeline timing: latency 2 cycles, throughput 1 per cycle.
- Per-stage advance: a stage loads when it is empty or its content moves on the same cycle.
- in_ready = !s1_valid | (s1 advances). Combinational from out_ready.
- Data stability: out_* hold stable while out_valid=1 and out_ready=0. Order is preserved and nothing is dropped.
- Stage 1, unpack:
  - exp field 0 → hidden bit 0, effective exponent 1. Otherwise hidden bit 1.
  - B sign ^= op_sub.
  - Magnitude compare on {exp, fraction}. B strictly greater → swap, out_swapped=1. Equal magnitudes → A stays large.
  - Register d = exp_l - exp_s (unsigned, EXP_W bits), both significands, signs and special flags.
- Stage 2, align:
  - d = 0: man_s unshifted.
  - 1 ≤ d ≤ SIG_W-1: man_s = sig_s >> d; bit 0 ORed with OR of all bits shifted out (sticky).
  - d ≥ SIG_W: man_s = 0 except bit 0 = OR(sig_s).
- Specials:
  - out_nan=1 if either operand is NaN, or if both are infinity with out_eff_sub=1.
  - out_inf=1 if either operand is infinity and out_nan=0.
  - Significand outputs remain computed as above.
- Zero operands are aligned normally; no special flag is raised for zero.

Optional Feature:
- Macro FP_ALIGN_FTZ_EN.
- Defined: subnormal inputs (exp=0, fraction≠0) are flushed to signed zero in stage 1 before the compare.
- Undefined: gradual underflow as described above.

Test Plan:
- a=0x3F800000, b=0x3F800000, op_sub=0 → after 2 cycles: out_exp=0x7F, out_man_l=out_man_s=0x4000000, out_eff_sub=0, out_swapped=0.
- a=0x40400000, b=0x3FC00000, op_sub=1 → out_exp=0x80, out_man_l=0x6000000, out_man_s=0x3000000, out_sign_s=1, out_eff_sub=1.
- a=0x3F800000, b=0x40000000 → out_swapped=1, out_exp=0x80, out_man_l=0x4000000, out_man_s=0x2000000.
- a=0x3F800000, b=0x30800000 (d=30) → out_man_s=0x0000001 (sticky only). Also a=0x7F800000, b=0x7F800000, op_sub=1 → out_nan=1.
- Backpressure: hold out_ready=0, offer 4 back-to-back inputs → exactly 2 accepted, then in_ready=0. Release out_ready → all results emerge in order, no duplicates, outputs stable while stalled.
- Drive rst_n=0 mid-stream with out_valid=1 → out_valid drops immediately, without waiting for clk. After release, in_ready=1 and the first new result appears 2 cycles after acceptance.
